// File: rtl/exec_sequencer_pkg.sv
// Shared opcode, state and instruction-field definitions for the exec_sequencer slice.
package exec_sequencer_pkg;

  typedef enum logic [1:0] {
    StWait  = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2,
    StHalt  = 2'd3
  } state_e;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_JZ   = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hE;
  localparam logic [3:0] OP_OUT  = 4'hF;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/exec_sequencer_tick_prescaler.sv
// Run-mode tick generator: one-cycle tick every TICK_DIV cycles while en is held high.
module exec_sequencer_tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] count_q;
  logic            at_top;

  assign at_top = (count_q == CntW'(TICK_DIV - 1));
  assign tick   = en && at_top;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (!en || at_top) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CntW'(1);
    end
  end

endmodule

// File: rtl/exec_sequencer.sv
// Instruction sequencer: PC, synchronous-ROM fetch, instruction register and datapath strobes
// with run/step/halt control and JZ/JMP flow on a sticky zero flag.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int unsigned ROM_SIZE = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              step,
  input  logic [15:0]       instruction,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       ir,
  output logic              rf_we,
  output logic              wb_sel,
  output logic              out_en,
  output logic              zero_flag,
  output logic              busy,
  output logic              halted
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, jump_tgt;
  logic [15:0]       ir_q;
  logic              zero_q;
  logic              tick, start;
  logic [3:0]        opc;

  exec_sequencer_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (run),
    .tick (tick)
  );

  assign start    = (run && tick) || (!run && step);
  assign opc      = opcode_of(ir_q);
  assign pc_inc   = (pc_q == ADDR_W'(ROM_SIZE - 1)) ? '0 : pc_q + ADDR_W'(1);
  // Targets beyond the populated ROM fold back into it.
  assign jump_tgt = ADDR_W'(32'(ir_q[ADDR_W-1:0]) % ROM_SIZE);

  always_comb begin
    pc_d   = pc_inc;
    rf_we  = 1'b0;
    wb_sel = 1'b0;
    out_en = 1'b0;
    case (opc)
      OP_NOP:  ;
      OP_LDI:  rf_we = 1'b1;
      OP_ADD,
      OP_SUB:  begin
        rf_we  = 1'b1;
        wb_sel = 1'b1;
      end
      OP_JZ:   if (zero_q) pc_d = jump_tgt;
      OP_JMP:  pc_d = jump_tgt;
      OP_HALT: pc_d = pc_q;
      OP_OUT:  out_en = 1'b1;
      default: ;
    endcase
    if (state_q != StExec) begin
      rf_we  = 1'b0;
      wb_sel = 1'b0;
      out_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StWait;
      pc_q    <= '0;
      ir_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StWait:  if (start) state_q <= StFetch;
        StFetch: begin
          ir_q    <= instruction;
          state_q <= StExec;
        end
        StExec:  begin
          pc_q <= pc_d;
          if (opc == OP_SUB) zero_q <= alu_zero;
          state_q <= (opc == OP_HALT) ? StHalt : StWait;
        end
        StHalt:  ;
        default: state_q <= StWait;
      endcase
    end
  end

  assign rom_addr  = pc_q;
  assign ir        = ir_q;
  assign zero_flag = zero_q;
  assign busy      = (state_q == StFetch) || (state_q == StExec);
  assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: ROM model, exec-cycle scoreboard, scenario tasks.
module tb_exec_sequencer;

  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n, run, step, alu_zero;
  logic [15:0]       instruction;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       ir;
  logic              rf_we, wb_sel, out_en, zero_flag, busy, halted;

  logic [15:0] rom [16];

  typedef struct packed {
    logic [15:0] ir;
    logic        rf_we;
    logic        wb_sel;
    logic        out_en;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic prev_busy = 1'b0;

  exec_sequencer #(
    .ROM_SIZE(16),
    .ADDR_W  (ADDR_W),
    .TICK_DIV(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .step       (step),
    .instruction(instruction),
    .alu_zero   (alu_zero),
    .rom_addr   (rom_addr),
    .ir         (ir),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .out_en     (out_en),
    .zero_flag  (zero_flag),
    .busy       (busy),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data appears the cycle after the address.
  always @(posedge clk) instruction <= rom[rom_addr];

  // Second consecutive busy cycle is EXEC; compare strobes against the scoreboard there.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (busy && prev_busy) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL exec_unexpected ir=%h required=no execution", ir);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({ir, rf_we, wb_sel, out_en} !== {e.ir, e.rf_we, e.wb_sel, e.out_en}) begin
            errors++;
            $display("FAIL exec_strobes ir=%h we=%b sel=%b out=%b required ir=%h we=%b sel=%b out=%b",
                     ir, rf_we, wb_sel, out_en, e.ir, e.rf_we, e.wb_sel, e.out_en);
          end
        end
      end else if ({rf_we, wb_sel, out_en} !== 3'b000) begin
        errors++;
        $display("FAIL idle_strobes we/sel/out=%b%b%b required 000", rf_we, wb_sel, out_en);
      end
    end
    prev_busy = busy;
  end

  task automatic push(input logic [15:0] i, input logic we, input logic sel, input logic oe);
    exp_t e;
    e.ir = i; e.rf_we = we; e.wb_sel = sel; e.out_en = oe;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    run = 1'b0; step = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_step(input string name);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    for (int i = 0; i < 8 && busy; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout busy=%b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    alu_zero = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    do_reset();
    mon_en = 1'b1;
    checks++;
    if ({rom_addr, ir, zero_flag, busy, halted, rf_we, wb_sel, out_en} !== '0) begin
      errors++;
      $display("FAIL reset_state pc=%h ir=%h z=%b busy=%b halt=%b required all zero",
               rom_addr, ir, zero_flag, busy, halted);
    end
  endtask

  task automatic test_run_tick();
    do_reset();
    rom[0] = 16'h1205;
    push(16'h1205, 1'b1, 1'b0, 1'b0);
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL run_early_start cycle=%0d busy=%b required 0", i + 1, busy);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL run_fourth_start busy=%b required 1", busy);
    end
    @(negedge clk);
    checks++;
    if ({rf_we, wb_sel, ir} !== {1'b1, 1'b0, 16'h1205}) begin
      errors++;
      $display("FAIL run_exec we=%b sel=%b ir=%h required 1 0 1205", rf_we, wb_sel, ir);
    end
    @(negedge clk);
    run = 1'b0;
    checks++;
    if ({rom_addr, busy} !== {4'd1, 1'b0}) begin
      errors++;
      $display("FAIL run_pc pc=%0d busy=%b required 1 0", rom_addr, busy);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (rom_addr !== 4'd1) begin
      errors++;
      $display("FAIL run_stop pc=%0d required 1", rom_addr);
    end
  endtask

  task automatic test_step();
    do_reset();
    rom[0] = 16'h0000; rom[1] = 16'h0000;
    push(16'h0000, 1'b0, 1'b0, 1'b0);
    step = 1'b1;
    @(negedge clk);              // FETCH
    step = 1'b0;
    @(negedge clk);              // EXEC: pulse arrives while busy
    step = 1'b1;
    @(negedge clk);              // WAIT
    step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({rom_addr, busy} !== {4'd1, 1'b0}) begin
        errors++;
        $display("FAIL step_ignored pc=%0d busy=%b required 1 0", rom_addr, busy);
      end
    end
    push(16'h0000, 1'b0, 1'b0, 1'b0);
    do_step("step_second");
    checks++;
    if (rom_addr !== 4'd2) begin
      errors++;
      $display("FAIL step_second_pc pc=%0d required 2", rom_addr);
    end
  endtask

  task automatic test_jz();
    do_reset();
    rom[0] = 16'h3000; rom[1] = 16'h400A;
    alu_zero = 1'b1;
    push(16'h3000, 1'b1, 1'b1, 1'b0);
    do_step("sub_z1");
    alu_zero = 1'b0;
    checks++;
    if ({zero_flag, rom_addr} !== {1'b1, 4'd1}) begin
      errors++;
      $display("FAIL sub_zero_set z=%b pc=%0d required 1 1", zero_flag, rom_addr);
    end
    push(16'h400A, 1'b0, 1'b0, 1'b0);
    do_step("jz_taken");
    checks++;
    if ({zero_flag, rom_addr} !== {1'b1, 4'd10}) begin
      errors++;
      $display("FAIL jz_taken z=%b pc=%0d required 1 10", zero_flag, rom_addr);
    end
    do_reset();
    alu_zero = 1'b0;
    push(16'h3000, 1'b1, 1'b1, 1'b0);
    do_step("sub_z0");
    alu_zero = 1'b1;
    push(16'h400A, 1'b0, 1'b0, 1'b0);
    do_step("jz_not_taken");
    checks++;
    if ({zero_flag, rom_addr} !== {1'b0, 4'd2}) begin
      errors++;
      $display("FAIL jz_not_taken z=%b pc=%0d required 0 2", zero_flag, rom_addr);
    end
    alu_zero = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    rom[0] = 16'h500F; rom[15] = 16'h0000;
    push(16'h500F, 1'b0, 1'b0, 1'b0);
    do_step("jmp_f");
    checks++;
    if (rom_addr !== 4'd15) begin
      errors++;
      $display("FAIL jmp_to_15 pc=%0d required 15", rom_addr);
    end
    push(16'h0000, 1'b0, 1'b0, 1'b0);
    do_step("wrap");
    checks++;
    if (rom_addr !== 4'd0) begin
      errors++;
      $display("FAIL pc_wrap pc=%0d required 0", rom_addr);
    end
    rom[0] = 16'h501F;
    push(16'h501F, 1'b0, 1'b0, 1'b0);
    do_step("jmp_1f");
    checks++;
    if (rom_addr !== 4'd15) begin
      errors++;
      $display("FAIL jmp_modulo pc=%0d required 15", rom_addr);
    end
  endtask

  task automatic test_out_halt();
    do_reset();
    rom[0] = 16'h3000; rom[1] = 16'hF200; rom[2] = 16'hE000;
    alu_zero = 1'b1;
    push(16'h3000, 1'b1, 1'b1, 1'b0);
    do_step("halt_sub");
    alu_zero = 1'b0;
    push(16'hF200, 1'b0, 1'b0, 1'b1);
    do_step("out");
    push(16'hE000, 1'b0, 1'b0, 1'b0);
    do_step("halt");
    checks++;
    if ({halted, rom_addr, zero_flag} !== {1'b1, 4'd2, 1'b1}) begin
      errors++;
      $display("FAIL halt_entry halt=%b pc=%0d z=%b required 1 2 1", halted, rom_addr, zero_flag);
    end
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step = (i % 3 == 0);
      @(negedge clk);
    end
    run = 1'b0; step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    checks++;
    if ({halted, busy, rom_addr} !== {1'b1, 1'b0, 4'd2}) begin
      errors++;
      $display("FAIL halt_absorbing halt=%b busy=%b pc=%0d required 1 0 2", halted, busy, rom_addr);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({rom_addr, halted, zero_flag} !== {4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL halt_reset pc=%0d halt=%b z=%b required 0 0 0", rom_addr, halted, zero_flag);
    end
  endtask

  task automatic test_reset_in_exec();
    do_reset();
    rom[0] = 16'h3000; rom[1] = 16'h2240;
    alu_zero = 1'b1;
    push(16'h3000, 1'b1, 1'b1, 1'b0);
    do_step("pre_sub");
    push(16'h2240, 1'b1, 1'b1, 1'b0);
    step = 1'b1;
    @(negedge clk);              // FETCH
    step = 1'b0;
    @(negedge clk);              // EXEC
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    alu_zero = 1'b0;
    checks++;
    if ({rom_addr, ir, zero_flag, busy, halted, rf_we, out_en} !== '0) begin
      errors++;
      $display("FAIL reset_in_exec pc=%0d ir=%h z=%b busy=%b halt=%b required all zero",
               rom_addr, ir, zero_flag, busy, halted);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog sim_time=%0t required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_run_tick();
    test_step();
    test_jz();
    test_wrap();
    test_out_halt();
    test_reset_in_exec();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Instruction-level controller for the 16-bit accumulator-style datapath (regfile + ALU + 16-entry instruction ROM). It owns the program counter, fetches from a synchronous ROM, and holds the registered instruction (ir). It drives regfile write enable, write-back select and output-latch strobe. It replaces free-running timer-based address stepping with run/step/halt control, a parameterised tick prescaler, and JZ/JMP control flow on a zero flag.

Parameters:
ROM_SIZE, 16, number of ROM words; PC wraps from ROM_SIZE-1 to 0
ADDR_W, 4, ROM address width; ROM_SIZE <= 2**ADDR_W
TICK_DIV, 50000000, clk cycles per run-mode instruction start; >= 1

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
run  in  1  level; free-run at one instruction per tick
step  in  1  single-cycle pulse; execute exactly one instruction when run=0
instruction  in  16  ROM data; valid the cycle after rom_addr is presented
alu_zero  in  1  ALU zero output for current ir operands
rom_addr  out  ADDR_W  program counter driven to ROM
ir  out  16  registered instruction; datapath takes reg_a=ir[11:9], reg_b=ir[8:6], imm=ir[7:0]
rf_we  out  1  regfile write enable, high only in EXEC
wb_sel  out  1  0 = zero-extended imm, 1 = alu_result
out_en  out  1  latch regfile data_a into result register, high only in EXEC
zero_flag  out  1  sticky zero status
busy  out  1  high in FETCH and EXEC
halted  out  1  high in HALT

Behaviour:
- Reset (rst_n=0 at a clk edge): state=WAIT, pc=0, ir=0, zero_flag=0, prescaler=0. rf_we, wb_sel, out_en, busy and halted are all 0. Reset wins in every state, including mid-instruction and HALT.
- Prescaler: counts 0..TICK_DIV-1 while run=1. tick=1 when count==TICK_DIV-1, then count wraps to 0. run=0 clears count to 0. TICK_DIV=1 gives tick every cycle.
- Start condition in WAIT: (run & tick) | (~run & step).
- step is ignored when run=1, in FETCH/EXEC and in HALT. step is never queued.
- FSM states: WAIT, FETCH, EXEC, HALT.
  - WAIT -> FETCH on start; otherwise stay.
  - FETCH lasts exactly 1 cycle, then goes to EXEC. At its exit edge: ir <= instruction.
  - EXEC lasts exactly 1 cycle. Strobes are decoded combinationally from ir and gated by state==EXEC. At its exit edge the PC and zero flag update, then the FSM goes to WAIT, or to HALT for opcode HALT.
  - HALT is absorbing until reset.
- Latency: start accepted at edge N; rf_we/out_en high during cycle N+2; next instruction can start no earlier than edge N+3.
- Opcodes (ir[15:12]):
  - 0000 NOP: pc+1.
  - 0001 LDI: rf_we=1, wb_sel=0; pc+1.
  - 0010 ADD: rf_we=1, wb_sel=1; pc+1.
  - 0011 SUB: rf_we=1, wb_sel=1, zero_flag <= alu_zero; pc+1.
  - 0100 JZ: if zero_flag then pc <= ir[ADDR_W-1:0], else pc+1.
  - 0101 JMP: pc <= ir[ADDR_W-1:0].
  - 1110 HALT: pc unchanged.
  - 1111 OUT: out_en=1; pc+1.
  - All other opcodes behave as NOP.
- PC increment: pc==ROM_SIZE-1 -> 0. Jump targets >= ROM_SIZE are taken modulo ROM_SIZE.
- zero_flag changes only on SUB; JZ reads the value held before the current EXEC.
- run deasserted during FETCH/EXEC: the instruction completes, then the FSM returns to WAIT and stays there.
- Only one of rf_we / out_en can be high in any cycle. wb_sel=0 whenever rf_we=0.

Decomposition:
- Shared package: opcode constants (OP_NOP, OP_LDI, OP_ADD, OP_SUB, OP_JZ, OP_JMP, OP_HALT, OP_OUT), FSM state encoding, instruction field bit positions.
- One sub-module: tick_prescaler (TICK_DIV, clk, rst_n, en=run -> tick).
- Decode and PC logic stay in exec_sequencer.

Test Plan:
1. Reset then run=1, TICK_DIV=4, ROM[0]=LDI r1,#5 (0x1205) -> first start at the 4th cycle; rf_we=1, wb_sel=0, ir=0x1205 two cycles later; rom_addr=1 afterwards.
2. run=0, one step pulse with ROM[0]=NOP -> exactly one FETCH/EXEC pair, rom_addr 0->1; a second step pulse during busy is ignored; rom_addr stays 1 until the next pulse.
3. SUB with alu_zero=1, then JZ #0xA -> zero_flag=1 after the SUB EXEC, rom_addr=10 after the JZ. Repeat with alu_zero=0 -> rom_addr=pc+1.
4. pc=15, NOP -> rom_addr wraps to 0. JMP #0x1F with ADDR_W=4 -> rom_addr=15.
5. OUT (0xF200) then HALT (0xE000) -> out_en pulses for exactly 1 cycle, halted=1, rom_addr frozen; run and step have no effect; rst_n=0 for one edge -> rom_addr=0, halted=0, zero_flag=0.
6. rst_n=0 asserted in EXEC of an ADD -> no state update from that EXEC; all outputs at reset values on the following cycle.
